// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter
// Description : Shares the SM83 external bus between the CPU core and an OAM
//               DMA engine. A CPU write of a source page to REG_ADDR copies
//               DMA_LEN bytes from {page, 8'h00} into OAM, one read M-cycle
//               and one write M-cycle per byte. While the engine owns the
//               main bus, CPU traffic below 0xFF00 is locked out; traffic to
//               0xFF00-0xFFFF continues on the high port.
//               Optional build macro SM83_DMA_ECHO_FOLD_EN folds echo source
//               pages (0xE0-0xFF) down by 0x20 onto work RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter #(
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int          DMA_LEN  = 160,
    parameter logic [15:0] REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_stb,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_write,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_write,
    input  logic [7:0]  mem_din,
    output logic [15:0] hi_addr,
    output logic [7:0]  hi_dout,
    output logic        hi_write,
    input  logic [7:0]  hi_din,
    output logic        dma_active
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DELAY = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    localparam logic [7:0] c_LAST_IDX = 8'(DMA_LEN - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_own;
    // Address driven during the previous M-cycle; replayed while a restart
    // sits in DELAY so the bus stays quiet and stable.
    logic [15:0] r_hold_addr;

    logic        w_trigger;
    logic        w_cpu_hi;
    logic        w_cpu_reg;
    logic [7:0]  w_src_page;
    logic [15:0] w_dma_rd_addr;
    logic [15:0] w_dma_wr_addr;

    assign w_cpu_reg = (cpu_addr == REG_ADDR);
    assign w_cpu_hi  = (cpu_addr >= 16'hFF00);
    assign w_trigger = m_stb & cpu_write & w_cpu_reg;

`ifdef SM83_DMA_ECHO_FOLD_EN
    assign w_src_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
`else
    assign w_src_page = r_page;
`endif

    assign w_dma_rd_addr = {w_src_page, r_idx};
    assign w_dma_wr_addr = OAM_BASE + {8'h00, r_idx};

    assign dma_active = r_own;

    // Main bus mux: CPU passes through unless the DMA engine owns the bus
    always_comb begin
        mem_addr  = cpu_addr;
        mem_dout  = cpu_dout;
        mem_write = cpu_write & ~w_cpu_hi;
        if (r_own) begin
            mem_dout = r_data;
            case (r_state)
                c_READ: begin
                    mem_addr  = w_dma_rd_addr;
                    mem_write = 1'b0;
                end
                c_WRITE: begin
                    mem_addr  = w_dma_wr_addr;
                    mem_write = 1'b1;
                end
                default: begin
                    mem_addr  = r_hold_addr;
                    mem_write = 1'b0;
                end
            endcase
        end
    end

    // CPU-side routing: register readback, high port, or (locked) main bus
    always_comb begin
        hi_addr  = cpu_addr;
        hi_dout  = cpu_dout;
        hi_write = cpu_write & w_cpu_hi & ~w_cpu_reg;
        if (w_cpu_reg) begin
            cpu_din = r_page;
        end else if (w_cpu_hi) begin
            cpu_din = hi_din;
        end else if (r_own) begin
            cpu_din = 8'hFF;
        end else begin
            cpu_din = mem_din;
        end
    end

    // DMA sequencer; a register write restarts the copy from any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_page      <= 8'h00;
            r_idx       <= 8'h00;
            r_data      <= 8'h00;
            r_own       <= 1'b0;
            r_hold_addr <= 16'h0000;
        end else if (m_stb) begin
            r_hold_addr <= mem_addr;
            if (w_trigger) begin
                r_page  <= cpu_dout;
                r_idx   <= 8'h00;
                r_state <= c_DELAY;
            end else begin
                case (r_state)
                    c_DELAY: begin
                        r_state <= c_READ;
                        r_own   <= 1'b1;
                    end
                    c_READ: begin
                        r_data  <= mem_din;
                        r_state <= c_WRITE;
                    end
                    c_WRITE: begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_IDLE;
                            r_own   <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= c_READ;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_bus_arbiter
// Description : Scoreboarded bench for dma_bus_arbiter. Directed stimulus
//               pushes the expected OAM writes into a queue; a monitor pops
//               and compares on every M-cycle that carries a main-bus write.
//               Honours SM83_DMA_ECHO_FOLD_EN for the echo-page expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_stb;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_write;
    logic [7:0]  cpu_din;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_write;
    logic [7:0]  mem_din;
    logic [15:0] hi_addr;
    logic [7:0]  hi_dout;
    logic        hi_write;
    logic [7:0]  hi_din;
    logic        dma_active;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        q_wr[$];
    logic [7:0] mem [0:65535];
    int         checks = 0;
    int         errors = 0;
    int         act_cnt = 0;
    int         a0;

`ifdef SM83_DMA_ECHO_FOLD_EN
    localparam logic [15:0] c_ECHO_SRC = 16'hC300;
    localparam logic [7:0]  c_ECHO_XOR = 8'h96;
`else
    localparam logic [15:0] c_ECHO_SRC = 16'hE300;
    localparam logic [7:0]  c_ECHO_XOR = 8'hC3;
`endif

    always #5 clk = ~clk;

    dma_bus_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_stb      (m_stb),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_write  (cpu_write),
        .cpu_din    (cpu_din),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_write  (mem_write),
        .mem_din    (mem_din),
        .hi_addr    (hi_addr),
        .hi_dout    (hi_dout),
        .hi_write   (hi_write),
        .hi_din     (hi_din),
        .dma_active (dma_active)
    );

    // Memory and high-port models
    assign mem_din = mem[mem_addr];
    assign hi_din  = hi_addr[7:0] ^ 8'hA5;

    // Main memory commits a write on the M-cycle edge
    always @(posedge clk) begin
        if (m_stb && mem_write) mem[mem_addr] <= mem_dout;
    end

    // Monitor: every main-bus write must match the head of the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (m_stb && dma_active) act_cnt++;
            if (m_stb && mem_write) begin
                checks++;
                if (q_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr %h data %h (none expected)", mem_addr, mem_dout);
                end else begin
                    e = q_wr.pop_front();
                    if (mem_addr !== e.a || mem_dout !== e.d) begin
                        errors++;
                        $display("FAIL dma_write got addr %h data %h exp addr %h data %h",
                                 mem_addr, mem_dout, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Close the previous M-cycle, open a new one, return inside its window
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(posedge clk); #2 m_stb = 1'b0;
        @(posedge clk); #2;
        cpu_addr  = a;
        cpu_dout  = d;
        cpu_write = w;
        m_stb     = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 8'h00, 1'b0);
    endtask

    task automatic push_copy(input logic [7:0] xv, input int first, input int cnt);
        for (int k = first; k < first + cnt; k++)
            q_wr.push_back({16'hFE00 + 16'(k), 8'(k) ^ xv});
    endtask

    initial begin
        rst_n = 1'b0; m_stb = 1'b0;
        cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_write = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'h3C;
            mem[16'hE300 + 16'(i)] = 8'(i) ^ 8'hC3;
            mem[16'hC300 + 16'(i)] = 8'(i) ^ 8'h96;
        end
        mem[16'h1234] = 8'h77;
        mem[16'hC000] = 8'h11;

        // Reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1; cpu_addr = 16'h1234;
        #1;
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_mem_write",  32'(mem_write),  32'd0);
        chk("rst_hi_write",   32'(hi_write),   32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'h1234);
        chk("rst_cpu_din",    32'(cpu_din),    32'h77);

        // Basic copy with lockout probes
        push_copy(8'h5A, 0, 160);
        a0 = act_cnt;
        step(16'hFF46, 8'hC1, 1'b1);
        chk("reg_write_not_forwarded", 32'(hi_write), 32'd0);
        for (int n = 1; n <= 321; n++) begin
            case (n)
                10: begin
                    step(16'h4000, 8'h00, 1'b0);
                    chk("lock_read_ff", 32'(cpu_din), 32'hFF);
                    chk("dma_read_addr", 32'(mem_addr), 32'hC104);
                end
                11: begin
                    step(16'hC000, 8'h99, 1'b1);
                    chk("dma_write_addr", 32'(mem_addr), 32'hFE04);
                    chk("dma_write_data", 32'(mem_dout), 32'h5E);
                end
                12: begin
                    step(16'hC000, 8'h99, 1'b1);
                    chk("lock_write_dropped", 32'(mem_write), 32'd0);
                end
                14: begin
                    step(16'hFF80, 8'h3C, 1'b1);
                    chk("hi_write_during_dma", 32'(hi_write), 32'd1);
                    chk("hi_addr_during_dma", 32'(hi_addr), 32'hFF80);
                end
                15: begin
                    step(16'hFF80, 8'h00, 1'b0);
                    chk("hi_read_during_dma", 32'(cpu_din), 32'h25);
                end
                default: step(16'h0000, 8'h00, 1'b0);
            endcase
        end
        step(16'hFF46, 8'h00, 1'b0);
        chk("page_readback", 32'(cpu_din), 32'hC1);
        chk("copy_done_inactive", 32'(dma_active), 32'd0);
        chk("active_mcycles", 32'(act_cnt - a0), 32'd320);
        chk("copy_queue_empty", 32'(q_wr.size()), 32'd0);
        chk("lock_mem_c000", 32'(mem[16'hC000]), 32'h11);
        chk("oam_last_byte", 32'(mem[16'hFE9F]), 32'hC5);

        // Restart at idx 50, then trigger on the final write with an echo page
        push_copy(8'h5A, 0, 50);
        step(16'hFF46, 8'hC1, 1'b1);
        idle(101);
        step(16'hFF46, 8'hD0, 1'b1);
        chk("restart_read_addr", 32'(mem_addr), 32'hC132);
        push_copy(8'h3C, 0, 160);
        step(16'h0000, 8'h00, 1'b0);
        chk("restart_delay_active", 32'(dma_active), 32'd1);
        chk("restart_delay_nowrite", 32'(mem_write), 32'd0);
        chk("restart_delay_hold", 32'(mem_addr), 32'hC132);
        step(16'h0000, 8'h00, 1'b0);
        chk("restart_first_read", 32'(mem_addr), 32'hD000);
        idle(318);
        step(16'hFF46, 8'hE3, 1'b1);
        chk("final_write_kept", 32'(mem_write), 32'd1);
        chk("final_write_addr", 32'(mem_addr), 32'hFE9F);
        push_copy(c_ECHO_XOR, 0, 160);
        step(16'h0000, 8'h00, 1'b0);
        chk("echo_delay_active", 32'(dma_active), 32'd1);
        chk("echo_delay_nowrite", 32'(mem_write), 32'd0);
        step(16'h0000, 8'h00, 1'b0);
        chk("echo_first_read", 32'(mem_addr), 32'(c_ECHO_SRC));
        idle(319);
        step(16'hFF46, 8'h00, 1'b0);
        chk("echo_done_inactive", 32'(dma_active), 32'd0);
        chk("echo_page_readback", 32'(cpu_din), 32'hE3);
        chk("echo_queue_empty", 32'(q_wr.size()), 32'd0);

        // Abort by reset while reading idx 10
        push_copy(8'h5A, 0, 10);
        step(16'hFF46, 8'hC1, 1'b1);
        idle(22);
        rst_n = 1'b0;
        step(16'h1234, 8'h00, 1'b0);
        rst_n = 1'b1;
        chk("abort_inactive", 32'(dma_active), 32'd0);
        chk("abort_nowrite", 32'(mem_write), 32'd0);
        chk("abort_cpu_addr", 32'(mem_addr), 32'h1234);
        chk("abort_cpu_din", 32'(cpu_din), 32'h77);
        idle(30);
        chk("abort_queue_empty", 32'(q_wr.size()), 32'd0);
        step(16'hFF46, 8'h00, 1'b0);
        chk("abort_page_cleared", 32'(cpu_din), 32'h00);

        @(posedge clk); #2 m_stb = 1'b0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
